// File: rtl/open_list_min_select.sv
// Min-f selector behind the parallel open list: one prefetched head per queue,
// global minimum presented to the expansion stage over valid/ready.
package open_list_pkg;
  typedef struct packed {
    logic [15:0] f;
    logic [15:0] g;
    logic [15:0] pos;
  } node_array_t;
endpackage

// state   | meaning
// EMPTY   | no node buffered; pops the queue when it is non-empty
// PENDING | pop issued last cycle; response (or drained) lands this cycle
// FULL    | head node buffered; waits to win the selection
module open_list_min_select
  import open_list_pkg::*;
#(
  parameter int NUM_QUEUES = 8,
  parameter int IDX_W      = $clog2(NUM_QUEUES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_QUEUES-1:0]         queue_empty,
  input  logic [NUM_QUEUES-1:0]         queue_node_valid,
  input  node_array_t [NUM_QUEUES-1:0]  queue_node,
  output logic [NUM_QUEUES-1:0]         queue_pop,
  output logic                          out_valid,
  input  logic                          out_ready,
  output node_array_t                   out_node,
  output logic [IDX_W-1:0]              out_queue,
  output logic                          search_exhausted
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PENDING,
    S_FULL
  } slot_state_t;

  slot_state_t slot_state [NUM_QUEUES];
  node_array_t slot_node  [NUM_QUEUES];

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  node_array_t      sel_node;
  logic             all_slots_empty;
  logic             load;

  always_comb begin
    queue_pop = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      queue_pop[i] = rst && !flush && (slot_state[i] == S_EMPTY) && !queue_empty[i];
    end
  end

  // Strict less-than keeps the lowest index on equal f.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_node  = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (slot_state[i] == S_FULL && (!sel_found || slot_node[i].f < sel_node.f)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_node  = slot_node[i];
      end
    end
  end

  always_comb begin
    all_slots_empty = 1'b1;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (slot_state[i] != S_EMPTY) all_slots_empty = 1'b0;
    end
  end

  assign load             = (!out_valid || out_ready) && sel_found;
  assign search_exhausted = (&queue_empty) && all_slots_empty && !out_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        slot_state[i] <= S_EMPTY;
        slot_node[i]  <= '0;
      end
      out_valid <= 1'b0;
      out_node  <= '0;
      out_queue <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        slot_state[i] <= S_EMPTY;
      end
      out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        case (slot_state[i])
          S_EMPTY: begin
            if (queue_pop[i]) slot_state[i] <= S_PENDING;
          end
          S_PENDING: begin
            // No response means the queue drained between status and pop.
            if (queue_node_valid[i]) begin
              slot_node[i]  <= queue_node[i];
              slot_state[i] <= S_FULL;
            end else begin
              slot_state[i] <= S_EMPTY;
            end
          end
          S_FULL: begin
            if (load && sel_idx == IDX_W'(i)) slot_state[i] <= S_EMPTY;
          end
          default: slot_state[i] <= S_EMPTY;
        endcase
      end
      if (load) begin
        out_valid <= 1'b1;
        out_node  <= sel_node;
        out_queue <= sel_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_open_list_min_select.sv
// Bench for open_list_min_select: behavioural upstream queues, scoreboard of
// expected outputs, vector table plus hand sequences for timing corners.
module tb_open_list_min_select;
  import open_list_pkg::*;

  localparam int NQ = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NQ-1:0]     queue_empty;
  logic [NQ-1:0]     queue_node_valid;
  node_array_t [NQ-1:0] queue_node;
  logic [NQ-1:0]     queue_pop;
  logic              out_valid;
  logic              out_ready;
  node_array_t       out_node;
  logic [2:0]        out_queue;
  logic              search_exhausted;

  open_list_min_select #(.NUM_QUEUES(NQ)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .queue_empty(queue_empty), .queue_node_valid(queue_node_valid),
    .queue_node(queue_node), .queue_pop(queue_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_node(out_node),
    .out_queue(out_queue), .search_exhausted(search_exhausted)
  );

  always #5 clk = ~clk;

  typedef struct { int q; int unsigned f; } exp_t;
  typedef struct {
    logic [NQ-1:0] mask;
    int unsigned   f  [NQ];
    int            n;
    int            eq [NQ];
  } vec_t;

  int unsigned up_f [NQ][$];
  logic [NQ-1:0] force_inv;
  exp_t exp_q [$];
  int checks = 0;
  int errors = 0;

  logic [NQ-1:0] s_pop;
  logic          s_valid, s_exh;
  node_array_t   s_node;
  logic [2:0]    s_q;

  function automatic node_array_t mk(int q, int unsigned f);
    node_array_t n;
    n.f   = f[15:0];
    n.g   = f[15:0] ^ 16'h5a5a;
    n.pos = 16'(q);
    return n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh_empty();
    for (int i = 0; i < NQ; i++) queue_empty[i] = (up_f[i].size() == 0) && !force_inv[i];
  endtask

  task automatic load_q(int q, int unsigned f, logic expect_out);
    exp_t e;
    up_f[q].push_back(f);
    if (expect_out) begin
      e.q = q; e.f = f;
      exp_q.push_back(e);
    end
    refresh_empty();
  endtask

  // Mid-cycle observation; a handshake seen here retires one scoreboard entry.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    s_pop = queue_pop; s_valid = out_valid; s_node = out_node;
    s_q = out_queue; s_exh = search_exhausted;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {61'd0, out_queue}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out_node", 64'(out_node), 64'(mk(e.q, e.f)));
        chk("out_queue", 64'(out_queue), 64'(e.q));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (s_pop[i] && !force_inv[i] && up_f[i].size() > 0) begin
        queue_node_valid[i] = 1'b1;
        queue_node[i] = mk(i, up_f[i].pop_front());
      end else begin
        queue_node_valid[i] = 1'b0;
        queue_node[i] = '0;
      end
    end
    refresh_empty();
  endtask

  task automatic run_until_drained(int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      sample(); advance(); n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic settle_idle();
    sample();
    chk("idle_out_valid", 64'(s_valid), 64'd0);
    chk("idle_exhausted", 64'(s_exh), 64'd1);
    advance();
  endtask

  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0].mask = 8'hFF; vecs[0].f = '{9, 5, 5, 7, 20, 5, 30, 8};
    vecs[0].n = 8; vecs[0].eq = '{1, 2, 5, 3, 7, 0, 4, 6};
    vecs[1].mask = 8'h08; vecs[1].f = '{0, 0, 0, 12, 0, 0, 0, 0};
    vecs[1].n = 1; vecs[1].eq = '{3, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].mask = 8'hA5; vecs[2].f = '{16'h7FFF, 0, 3, 0, 0, 3, 0, 16'h8000};
    vecs[2].n = 4; vecs[2].eq = '{2, 5, 0, 7, 0, 0, 0, 0};
    vecs[3].mask = 8'hF0; vecs[3].f = '{0, 0, 0, 0, 7, 7, 7, 7};
    vecs[3].n = 4; vecs[3].eq = '{4, 5, 6, 7, 0, 0, 0, 0};

    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; force_inv = '0;
    queue_node_valid = '0; queue_node = '0; s_pop = '0;
    for (int i = 0; i < NQ; i++) up_f[i].push_back(10 + i);
    refresh_empty();

    // Reset held with every queue non-empty.
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("rst_pop", 64'(s_pop), 64'd0);
      chk("rst_out_valid", 64'(s_valid), 64'd0);
      advance();
    end
    sample();
    chk("rst_out_node", 64'(s_node), 64'd0);
    chk("rst_out_queue", 64'(s_q), 64'd0);
    advance();
    rst = 1'b1;
    for (int i = 0; i < NQ; i++) begin
      exp_t e; e.q = i; e.f = 10 + i; exp_q.push_back(e);
    end
    sample();
    chk("release_pop", 64'(s_pop), 64'hFF);
    advance();
    run_until_drained(40);
    settle_idle();

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        exp_t e; e.q = vecs[v].eq[k]; e.f = vecs[v].f[vecs[v].eq[k]];
        exp_q.push_back(e);
      end
      for (int i = 0; i < NQ; i++)
        if (vecs[v].mask[i]) load_q(i, vecs[v].f[i], 1'b0);
      run_until_drained(40);
      settle_idle();
    end

    // Single queue latency and immediate re-pop.
    load_q(3, 12, 1'b1); load_q(3, 15, 1'b1);
    sample(); chk("sq_pop_c0", 64'(s_pop), 64'h08); advance();
    sample(); chk("sq_pop_c1", 64'(s_pop), 64'h00); chk("sq_valid_c1", 64'(s_valid), 64'd0); advance();
    sample(); chk("sq_valid_c2", 64'(s_valid), 64'd0); advance();
    sample();
    chk("sq_valid_c3", 64'(s_valid), 64'd1);
    chk("sq_f_c3", 64'(s_node.f), 64'd12);
    chk("sq_repop_c3", 64'(s_pop), 64'h08);
    advance();
    run_until_drained(20);
    settle_idle();

    // Backpressure: head must not be displaced by a smaller late arrival.
    out_ready = 1'b0;
    load_q(0, 4, 1'b1);
    for (int c = 0; c < 3; c++) begin sample(); advance(); end
    load_q(1, 2, 1'b1);
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("bp_valid", 64'(s_valid), 64'd1);
      chk("bp_f", 64'(s_node.f), 64'd4);
      advance();
    end
    out_ready = 1'b1;
    run_until_drained(20);
    settle_idle();

    // Drained queue: status says non-empty but the pop returns nothing.
    force_inv[6] = 1'b1; refresh_empty();
    sample(); chk("dr_pop_c0", 64'(s_pop), 64'h40); advance();
    sample(); chk("dr_pop_c1", 64'(s_pop), 64'h00); advance();
    sample(); chk("dr_repop_c2", 64'(s_pop), 64'h40); chk("dr_valid_c2", 64'(s_valid), 64'd0); advance();
    sample(); advance();
    force_inv[6] = 1'b0; refresh_empty();
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("dr_no_pop", 64'(s_pop), 64'h00);
      chk("dr_no_out", 64'(s_valid), 64'd0);
      advance();
    end
    settle_idle();

    // Flush with four FULL slots, one output held, two pops in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) load_q(i, 50 - 10 * i, 1'b0);
    sample(); chk("fl_pop_c0", 64'(s_pop), 64'h1F); advance();
    sample(); advance();
    sample(); advance();
    load_q(5, 1, 1'b0); load_q(6, 1, 1'b0);
    sample();
    chk("fl_valid_c3", 64'(s_valid), 64'd1);
    chk("fl_f_c3", 64'(s_node.f), 64'd10);
    chk("fl_pop_c3", 64'(s_pop), 64'h60);
    advance();
    flush = 1'b1;
    sample(); chk("fl_pop_blocked", 64'(s_pop), 64'h00); advance();
    flush = 1'b0;
    sample();
    chk("fl_out_valid", 64'(s_valid), 64'd0);
    chk("fl_exhausted", 64'(s_exh), 64'd1);
    advance();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      chk("fl_no_out", 64'(s_valid), 64'd0);
      advance();
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/open_list_min_select.md
Name: open_list_min_select

Overview:
- Downstream consumer of the NUM_QUEUES-way parallel open list.
- Keeps one prefetched head node per queue and drives each queue's pop_enable.
- Presents the single global minimum-f node to the A* expansion stage over a valid/ready handshake.
- Flags search exhaustion (no path) when every queue and every buffer is empty.

Parameters:
- NUM_QUEUES, 8, number of open-list queues served; must match the open list instance.
- IDX_W, $clog2(NUM_QUEUES), width of the selected-queue index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (sampled on rising edge of clk, asserted when 0).
- flush  input  1  synchronous clear of all slots and the output register (new search).
- queue_empty  input  NUM_QUEUES  per-queue "no valid node in queue" status from the open list.
- queue_node_valid  input  NUM_QUEUES  per-queue pop response valid, one cycle after pop.
- queue_node  input  NUM_QUEUES x $bits(node_array_t)  per-queue popped node (node_array_t).
- queue_pop  output  NUM_QUEUES  pop_enable to the open list; combinational from slot state.
- out_valid  output  1  output register holds a node.
- out_ready  input  1  expansion stage accepts out_node.
- out_node  output  $bits(node_array_t)  global minimum-f node.
- out_queue  output  IDX_W  index of the queue out_node came from.
- search_exhausted  output  1  all slots EMPTY, all queue_empty high, out_valid low.

Behaviour:
- Reset values (rst=0 at an edge): all slots EMPTY, out_valid=0, out_node=0, out_queue=0. queue_pop=0 while rst=0. search_exhausted is combinational and follows from the reset state.
- Per-queue slot FSM, three states:
  - EMPTY: queue_pop[i]=1 iff !queue_empty[i] && !flush. If popped, next state is PENDING.
  - PENDING: queue_pop[i]=0. At the next edge, queue_node_valid[i]=1 → capture queue_node[i] and go FULL. Otherwise go EMPTY (queue was drained; no error).
  - FULL: holds the node. Goes EMPTY only when its node is loaded into the output register.
  - At most one outstanding pop per queue.
- Selection: combinational minimum over FULL slots.
  - Compare node.f as unsigned, full field width.
  - Tie on equal f → lowest queue index wins.
- Output register load condition: (!out_valid || out_ready) && at least one FULL slot. On load:
  - out_node/out_queue take the winner; out_valid=1.
  - The winning slot goes EMPTY at the same edge.
- If out_valid && out_ready and no FULL slot exists, out_valid drops to 0 at the edge.
- out_node/out_queue are stable while out_valid && !out_ready.
- Latency, empty system: pop asserted in cycle C0 → slot FULL in C2 → out_valid in C3.
- Throughput: one node per cycle while slots refill. A slot drained in cycle C can re-pop in C+1.
- A slot that has just gone EMPTY may re-pop in the same cycle the output loads only from the next cycle (EMPTY observed after the edge).
- Ordering: out_node is the minimum over buffered heads only. Global exactness holds because each queue is itself sorted ascending.
- flush=1 at an edge:
  - All slots go EMPTY; out_valid=0. Responses arriving in the following cycle are ignored.
  - flush has priority over capture and load.
  - Upstream is flushed by the same controller.
- rst mid-operation: same as flush, plus out_node/out_queue are cleared to 0.
- search_exhausted = &queue_empty && all slots EMPTY && !out_valid. Combinational; the controller qualifies it as stable for 2 cycles.

Test Plan:
- Reset: hold rst=0 for 3 cycles with queue_empty=0 → queue_pop=0, out_valid=0. After release, queue_pop=8'hFF in the first cycle.
- Single queue: only queue 3 non-empty with f=12; response valid next cycle → out_valid in the 3rd cycle after pop, out_node.f=12, out_queue=3. Slot 3 re-pops the following cycle.
- Tie/min: slots FULL with f={9,5,5,7,20,5,30,8} for queues 0..7 → outputs in order queue1(5), queue2(5), queue5(5), queue3(7). out_ready held high.
- Backpressure: out_valid=1 with f=4 and out_ready=0 for 5 cycles while a queue delivers f=2 → out_node stays f=4 throughout. After out_ready=1, the next output is f=2.
- Drained queue: pop queue 6 with queue_node_valid[6]=0 in the response cycle → slot 6 returns to EMPTY, no output. Raising queue_empty[6] → no further pops.
- Flush/exhaustion: flush while 4 slots are FULL and 2 are PENDING → out_valid=0 next cycle and late responses are ignored. With queue_empty=8'hFF, search_exhausted=1.
